bullet_engine: RTL and testbench



---
 rtl/bullet_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_bullet_engine.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_engine.sv
`default_nettype none
// bullet_engine: one bullet per player with fire/fly/cooldown FSMs, wall and tank collision,
// saturating hit scores and an RGB bullet overlay for the current raster pixel. Revision 1.0
module bullet_engine #(
  parameter int COLOR_BITS     = 24,
  parameter int BULLET_SPEED   = 2,
  parameter int BULLET_SIZE    = 4,
  parameter int COOLDOWN_TICKS = 8,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    move_tick_i,
  input  logic [3:0]              player_1_move_i,
  input  logic [3:0]              player_2_move_i,
  input  logic                    player_1_shoot_i,
  input  logic                    player_2_shoot_i,
  input  logic [9:0]              player_1_x_i,
  input  logic [9:0]              player_1_y_i,
  input  logic [9:0]              player_2_x_i,
  input  logic [9:0]              player_2_y_i,
  input  logic [9:0]              hpos_i,
  input  logic [9:0]              vpos_i,
  input  logic                    display_enable_i,
  input  logic                    cannot_walk_through_i,
  input  logic                    shoot_through_block_i,
  output logic [COLOR_BITS/3-1:0] bullet_red_o,
  output logic [COLOR_BITS/3-1:0] bullet_green_o,
  output logic [COLOR_BITS/3-1:0] bullet_blue_o,
  output logic [1:0]              bullet_active_o,
  output logic                    bullet_collide_o,
  output logic                    player_1_hit_o,
  output logic                    player_2_hit_o,
  output logic [3:0]              player_1_score_o,
  output logic [3:0]              player_2_score_o
);

  localparam int CW     = COLOR_BITS / 3;
  localparam int TANK   = 32;
  localparam int CENTER = (TANK - BULLET_SIZE) / 2;
  localparam int HIT_LO = 2;
  localparam int HIT_HI = TANK - 3;
  localparam int MAX_X  = SCREEN_W - BULLET_SIZE;
  localparam int MAX_Y  = SCREEN_H - BULLET_SIZE;
  localparam int CD_W   = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  logic [1:0][9:0] tank_x, tank_y;
  logic [1:0][3:0] move;
  logic [1:0]      shoot;
  logic [1:0]      flying, draw, hit_evt, wall_evt;
  logic [1:0][3:0] score;
  logic [1:0]      hit_pulse;
  logic            collide_pulse;

  assign tank_x = {player_2_x_i, player_1_x_i};
  assign tank_y = {player_2_y_i, player_1_y_i};
  assign move   = {player_2_move_i, player_1_move_i};
  assign shoot  = {player_2_shoot_i, player_1_shoot_i};

  for (genvar i = 0; i < 2; i++) begin : g_bullet
    localparam int OPP = 1 - i;
    localparam logic [3:0] FACE_RST = (i == 0) ? 4'b0001 : 4'b0010;

    state_t          state, state_next;
    logic [9:0]      bx, bx_next, by, by_next;
    logic [3:0]      dir, dir_next, facing;
    logic [CD_W-1:0] cd, cd_next;
    logic [3:0]      score_r;
    logic            prev_shoot, wall, fire, in_box, scan_hit, opp_hit, leaves;
    logic            hit, wall_hit;
    logic [10:0]     bx_w, by_w, ox_w, oy_w, h_w, v_w;

    assign bx_w = {1'b0, bx};
    assign by_w = {1'b0, by};
    assign ox_w = {1'b0, tank_x[OPP]};
    assign oy_w = {1'b0, tank_y[OPP]};
    assign h_w  = {1'b0, hpos_i};
    assign v_w  = {1'b0, vpos_i};

    assign fire   = shoot[i] & ~prev_shoot;
    assign in_box = (h_w >= bx_w) && (h_w <= bx_w + 11'(BULLET_SIZE - 1)) &&
                    (v_w >= by_w) && (v_w <= by_w + 11'(BULLET_SIZE - 1));
    assign scan_hit = (state == FLY) && display_enable_i && in_box &&
                      cannot_walk_through_i && !shoot_through_block_i;
    // Opponent hitbox is the tank square shrunk by two pixels on each side.
    assign opp_hit = (bx_w + 11'(BULLET_SIZE - 1) >= ox_w + 11'(HIT_LO)) &&
                     (bx_w <= ox_w + 11'(HIT_HI)) &&
                     (by_w + 11'(BULLET_SIZE - 1) >= oy_w + 11'(HIT_LO)) &&
                     (by_w <= oy_w + 11'(HIT_HI));

    always_comb begin
      leaves = 1'b0;
      case (dir)
        4'b0001: leaves = (by_w + 11'(BULLET_SPEED)) > 11'(MAX_Y);
        4'b0010: leaves = by < 10'(BULLET_SPEED);
        4'b0100: leaves = (bx_w + 11'(BULLET_SPEED)) > 11'(MAX_X);
        4'b1000: leaves = bx < 10'(BULLET_SPEED);
        default: leaves = 1'b0;
      endcase
    end

    always_comb begin
      state_next = state;
      bx_next    = bx;
      by_next    = by;
      dir_next   = dir;
      cd_next    = cd;
      hit        = 1'b0;
      wall_hit   = 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            bx_next    = tank_x[i] + 10'(CENTER);
            by_next    = tank_y[i] + 10'(CENTER);
            dir_next   = facing;
            state_next = FLY;
          end
        end
        FLY: begin
          if (move_tick_i) begin
            if (opp_hit) begin
              hit        = 1'b1;
              state_next = COOLDOWN;
              cd_next    = '0;
            end else if (wall) begin
              wall_hit   = 1'b1;
              state_next = COOLDOWN;
              cd_next    = '0;
            end else if (leaves) begin
              state_next = COOLDOWN;
              cd_next    = '0;
            end else begin
              case (dir)
                4'b0001: by_next = by + 10'(BULLET_SPEED);
                4'b0010: by_next = by - 10'(BULLET_SPEED);
                4'b0100: bx_next = bx + 10'(BULLET_SPEED);
                4'b1000: bx_next = bx - 10'(BULLET_SPEED);
                default: ;
              endcase
            end
          end
        end
        COOLDOWN: begin
          if (move_tick_i) begin
            if (cd == CD_W'(COOLDOWN_TICKS - 1)) begin
              state_next = IDLE;
              cd_next    = '0;
            end else begin
              cd_next = cd + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        state <= IDLE;
        bx    <= '0;
        by    <= '0;
        dir   <= FACE_RST;
        cd    <= '0;
      end else begin
        state <= state_next;
        bx    <= bx_next;
        by    <= by_next;
        dir   <= dir_next;
        cd    <= cd_next;
      end
    end

    // The previous-shoot sample resets high so a button held through reset cannot fire.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        facing     <= FACE_RST;
        prev_shoot <= 1'b1;
        wall       <= 1'b0;
        score_r    <= '0;
      end else begin
        prev_shoot <= shoot[i];
        if ($onehot(move[i])) facing <= move[i];
        if (move_tick_i) wall <= 1'b0;
        else if (scan_hit) wall <= 1'b1;
        if (hit && score_r != 4'hF) score_r <= score_r + 4'd1;
      end
    end

    assign flying[i]   = (state == FLY);
    assign draw[i]     = (state == FLY) && in_box;
    assign hit_evt[i]  = hit;
    assign wall_evt[i] = wall_hit;
    assign score[i]    = score_r;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hit_pulse     <= '0;
      collide_pulse <= 1'b0;
    end else begin
      hit_pulse     <= hit_evt;
      collide_pulse <= |wall_evt;
    end
  end

  // Bullet 1 is yellow and drawn on top of bullet 2, which is cyan.
  assign bullet_red_o   = (display_enable_i && draw[0]) ? {CW{1'b1}} : '0;
  assign bullet_green_o = (display_enable_i && (|draw)) ? {CW{1'b1}} : '0;
  assign bullet_blue_o  = (display_enable_i && !draw[0] && draw[1]) ? {CW{1'b1}} : '0;

  assign bullet_active_o  = flying;
  assign bullet_collide_o = collide_pulse;
  assign player_1_hit_o   = hit_pulse[1];
  assign player_2_hit_o   = hit_pulse[0];
  assign player_1_score_o = score[0];
  assign player_2_score_o = score[1];

endmodule
`default_nettype wire

// File: tb/tb_bullet_engine.sv
`default_nettype none
// tb_bullet_engine: directed scenarios plus randomized play, every cycle compared
// against a cycle-level behavioural model of the two bullets.
module tb_bullet_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       move_tick;
  logic [3:0] move [2];
  logic       shoot [2];
  logic [9:0] tank_x [2];
  logic [9:0] tank_y [2];
  logic [9:0] hpos, vpos;
  logic       de, cwt, stb;
  logic [7:0] red, green, blue;
  logic [1:0] active;
  logic       collide, hit1, hit2;
  logic [3:0] score1, score2;

  bullet_engine dut (
    .clk_i                 (clk),
    .reset_ni              (reset_n),
    .move_tick_i           (move_tick),
    .player_1_move_i       (move[0]),
    .player_2_move_i       (move[1]),
    .player_1_shoot_i      (shoot[0]),
    .player_2_shoot_i      (shoot[1]),
    .player_1_x_i          (tank_x[0]),
    .player_1_y_i          (tank_y[0]),
    .player_2_x_i          (tank_x[1]),
    .player_2_y_i          (tank_y[1]),
    .hpos_i                (hpos),
    .vpos_i                (vpos),
    .display_enable_i      (de),
    .cannot_walk_through_i (cwt),
    .shoot_through_block_i (stb),
    .bullet_red_o          (red),
    .bullet_green_o        (green),
    .bullet_blue_o         (blue),
    .bullet_active_o       (active),
    .bullet_collide_o      (collide),
    .player_1_hit_o        (hit1),
    .player_2_hit_o        (hit2),
    .player_1_score_o      (score1),
    .player_2_score_o      (score2)
  );

  always #5 clk = ~clk;

  // Model: state 0 idle, 1 flying, 2 cooling down; direction as (dx,dy) unit steps.
  int m_state [2], m_x [2], m_y [2], m_dx [2], m_dy [2], m_fx [2], m_fy [2];
  int m_cd [2], m_score [2];
  bit m_wall [2], m_prev [2], m_hit [2];
  bit m_coll;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_state[b] = 0; m_x[b] = 0; m_y[b] = 0; m_dx[b] = 0; m_dy[b] = 0;
      m_cd[b] = 0; m_score[b] = 0; m_wall[b] = 0; m_prev[b] = 1; m_hit[b] = 0;
      m_fx[b] = 0;
    end
    m_fy[0] = 1;
    m_fy[1] = -1;
    m_coll = 0;
  endtask

  function automatic bit m_in_box(int b, int h, int v);
    return m_state[b] == 1 && h >= m_x[b] && h <= m_x[b] + 3 &&
           v >= m_y[b] && v <= m_y[b] + 3;
  endfunction

  task automatic model_step();
    bit scan [2];
    bit hitp [2];
    bit coll, fire;
    int o, ox, oy, nx, ny;
    if (!reset_n) begin
      model_reset();
      return;
    end
    hitp[0] = 0; hitp[1] = 0; coll = 0;
    for (int b = 0; b < 2; b++) scan[b] = de && cwt && !stb && m_in_box(b, int'(hpos), int'(vpos));
    for (int b = 0; b < 2; b++) begin
      o = 1 - b;
      ox = int'(tank_x[o]);
      oy = int'(tank_y[o]);
      fire = shoot[b] && !m_prev[b];
      if (m_state[b] == 0) begin
        if (fire) begin
          m_x[b] = (int'(tank_x[b]) + 14) % 1024;
          m_y[b] = (int'(tank_y[b]) + 14) % 1024;
          m_dx[b] = m_fx[b];
          m_dy[b] = m_fy[b];
          m_state[b] = 1;
        end
      end else if (m_state[b] == 1) begin
        if (move_tick) begin
          nx = m_x[b] + 2 * m_dx[b];
          ny = m_y[b] + 2 * m_dy[b];
          if (m_x[b] + 3 >= ox + 2 && m_x[b] <= ox + 29 && m_y[b] + 3 >= oy + 2 && m_y[b] <= oy + 29) begin
            hitp[o] = 1;
            if (m_score[b] < 15) m_score[b]++;
            m_state[b] = 2; m_cd[b] = 8;
          end else if (m_wall[b]) begin
            coll = 1;
            m_state[b] = 2; m_cd[b] = 8;
          end else if (nx < 0 || nx > 636 || ny < 0 || ny > 476) begin
            m_state[b] = 2; m_cd[b] = 8;
          end else begin
            m_x[b] = nx; m_y[b] = ny;
          end
        end
      end else if (move_tick) begin
        m_cd[b]--;
        if (m_cd[b] == 0) m_state[b] = 0;
      end
      if (move_tick) m_wall[b] = 0;
      else if (scan[b]) m_wall[b] = 1;
      case (move[b])
        4'b0001: begin m_fx[b] = 0;  m_fy[b] = 1;  end
        4'b0010: begin m_fx[b] = 0;  m_fy[b] = -1; end
        4'b0100: begin m_fx[b] = 1;  m_fy[b] = 0;  end
        4'b1000: begin m_fx[b] = -1; m_fy[b] = 0;  end
        default: ;
      endcase
      m_prev[b] = shoot[b];
    end
    m_hit = hitp;
    m_coll = coll;
  endtask

  function automatic logic [31:0] m_rgb();
    if (!de) return 32'h0;
    if (m_in_box(0, int'(hpos), int'(vpos))) return 32'hFFFF00;
    if (m_in_box(1, int'(hpos), int'(vpos))) return 32'h00FFFF;
    return 32'h0;
  endfunction

  task automatic compare_all();
    logic [1:0] ea;
    ea = {m_state[1] == 1, m_state[0] == 1};
    check("active", {30'd0, active}, {30'd0, ea});
    check("pulses", {29'd0, collide, hit1, hit2}, {29'd0, m_coll, m_hit[0], m_hit[1]});
    check("scores", {24'd0, score2, score1}, {24'd0, 4'(m_score[1]), 4'(m_score[0])});
    check("rgb", {8'd0, red, green, blue}, m_rgb());
  endtask

  // Inputs are applied at the falling edge; one full clock cycle with a model check.
  task automatic cycle();
    if (!reset_n) model_reset();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic tick();
    move_tick = 1'b1; cycle();
    move_tick = 1'b0; cycle();
  endtask

  task automatic press(input int b);
    shoot[b] = 1'b1; cycle();
    shoot[b] = 1'b0; cycle();
  endtask

  task automatic probe(input int h, input int v, output logic [31:0] rgb);
    hpos = 10'(h);
    vpos = 10'(v);
    #1;
    rgb = {8'd0, red, green, blue};
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cycle(); cycle();
    reset_n = 1'b1; cycle();
  endtask

  int clamp_v;
  function automatic int clamp(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  initial begin
    logic [31:0] rgb;
    int n, got, r, h, v, b;
    reset_n = 1'b0; move_tick = 1'b0;
    move[0] = 4'b0; move[1] = 4'b0; shoot[0] = 1'b0; shoot[1] = 1'b0;
    tank_x[0] = 10'd224; tank_y[0] = 10'd64; tank_x[1] = 10'd224; tank_y[1] = 10'd416;
    hpos = '0; vpos = '0; de = 1'b1; cwt = 1'b0; stb = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    check("reset_scores", {24'd0, score2, score1}, 32'd0);

    // Fire from P1 straight down, then walk it onto P2.
    press(0);
    check("fire_active", {30'd0, active}, 32'd1);
    probe(238, 78, rgb); check("fire_pos", rgb, 32'hFFFF00);
    probe(237, 78, rgb); check("fire_edge", rgb, 32'h0);
    hpos = '0; vpos = '0;
    repeat (3) tick();
    probe(238, 84, rgb); check("move_down", rgb, 32'hFFFF00);
    probe(238, 83, rgb); check("move_down_edge", rgb, 32'h0);
    hpos = '0; vpos = '0;
    got = 0; n = 0;
    while (n < 300 && got == 0) begin
      n++;
      move_tick = 1'b1; cycle(); move_tick = 1'b0;
      if (hit2) got = 1;
      cycle();
    end
    check("p2_hit_seen", got, 1);
    check("hit_tick_count", n, 167);
    check("hit_one_cycle", {31'd0, hit2}, 32'd0);
    check("hit_score", {28'd0, score1}, 32'd1);
    check("hit_inactive", {31'd0, active[0]}, 32'd0);
    repeat (7) tick();
    press(0);
    check("cooldown_discard", {31'd0, active[0]}, 32'd0);
    tick();
    press(0);
    check("refire", {31'd0, active[0]}, 32'd1);

    // Reset mid-flight aborts the bullet silently.
    reset_n = 1'b0; cycle();
    check("abort_active", {30'd0, active}, 32'd0);
    check("abort_score", {28'd0, score1}, 32'd0);
    reset_n = 1'b1; cycle();

    // Wall pixel seen inside the bullet box, then a tick.
    press(0);
    hpos = 10'd239; vpos = 10'd79; cwt = 1'b1; cycle();
    cwt = 1'b0; hpos = '0; vpos = '0;
    move_tick = 1'b1; cycle(); move_tick = 1'b0;
    check("wall_collide", {31'd0, collide}, 32'd1);
    check("wall_no_score", {28'd0, score1}, 32'd0);
    check("wall_despawn", {31'd0, active[0]}, 32'd0);
    cycle();
    repeat (8) tick();
    press(0);
    hpos = 10'd239; vpos = 10'd79; cwt = 1'b1; stb = 1'b1; cycle();
    cwt = 1'b0; stb = 1'b0; hpos = '0; vpos = '0;
    move_tick = 1'b1; cycle(); move_tick = 1'b0;
    check("shoot_through", {31'd0, collide}, 32'd0);
    probe(238, 80, rgb); check("shoot_through_move", rgb, 32'hFFFF00);
    hpos = 10'd239; vpos = 10'd81; cwt = 1'b1; move_tick = 1'b1; cycle();
    cwt = 1'b0; move_tick = 1'b0; hpos = '0; vpos = '0;
    move_tick = 1'b1; cycle(); move_tick = 1'b0;
    check("scan_tick_drop", {31'd0, collide}, 32'd0);
    do_reset();

    // P2 facing left runs off the left edge silently.
    tank_x[1] = 10'd1; tank_y[1] = 10'd300;
    move[1] = 4'b1000; cycle();
    move[1] = 4'b1010; cycle();
    move[1] = 4'b0000;
    press(1);
    probe(15, 314, rgb); check("p2_spawn", rgb, 32'h00FFFF);
    hpos = '0; vpos = '0;
    repeat (7) tick();
    probe(1, 314, rgb); check("p2_left_edge", rgb, 32'h00FFFF);
    hpos = '0; vpos = '0;
    move_tick = 1'b1; cycle(); move_tick = 1'b0;
    check("silent_despawn", {29'd0, collide, hit1, hit2}, 32'd0);
    check("silent_inactive", {31'd0, active[1]}, 32'd0);
    do_reset();

    // Both bullets resolve on the same tick.
    tank_x[1] = 10'd224; tank_y[1] = 10'd80;
    shoot[0] = 1'b1; shoot[1] = 1'b1; cycle();
    shoot[0] = 1'b0; shoot[1] = 1'b0; cycle();
    tick();
    move_tick = 1'b1; cycle(); move_tick = 1'b0;
    check("dual_hit", {30'd0, hit1, hit2}, 32'd3);
    check("dual_score", {24'd0, score2, score1}, 32'h11);
    cycle();
    do_reset();

    // Score saturation at 15.
    for (int k = 1; k <= 16; k++) begin
      press(0);
      tick();
      move_tick = 1'b1; cycle(); move_tick = 1'b0;
      if (k == 16) begin
        check("sat_pulse", {31'd0, hit2}, 32'd1);
        check("sat_score", {28'd0, score1}, 32'd15);
      end
      cycle();
      repeat (8) tick();
    end

    // Shoot held across reset release does not fire.
    shoot[0] = 1'b1;
    do_reset();
    cycle(); cycle();
    check("held_no_fire", {30'd0, active}, 32'd0);
    shoot[0] = 1'b0; cycle();
    shoot[0] = 1'b1; cycle();
    check("repress_fire", {31'd0, active[0]}, 32'd1);
    shoot[0] = 1'b0;
    do_reset();

    // Randomized play.
    for (int ph = 0; ph < 30; ph++) begin
      tank_x[0] = 10'($urandom_range(0, 608));
      tank_y[0] = 10'($urandom_range(0, 448));
      if ($urandom_range(0, 1) == 0) begin
        tank_x[1] = 10'(clamp(int'(tank_x[0]) + int'($urandom_range(0, 8)) - 4, 0, 608));
        tank_y[1] = 10'($urandom_range(0, 448));
      end else begin
        tank_x[1] = 10'($urandom_range(0, 608));
        tank_y[1] = 10'(clamp(int'(tank_y[0]) + int'($urandom_range(0, 8)) - 4, 0, 448));
      end
      for (int c = 0; c < 150; c++) begin
        reset_n = ($urandom_range(0, 399) != 0);
        move_tick = ($urandom_range(0, 3) == 0);
        for (int p = 0; p < 2; p++) begin
          r = $urandom_range(0, 7);
          if (r < 4) move[p] = 4'(1 << r);
          else if (r == 4) move[p] = 4'b0;
          else if (r == 5) move[p] = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 2) == 0) shoot[p] = ~shoot[p];
        end
        b = $urandom_range(0, 1);
        if (m_state[b] == 1) begin
          h = m_x[b] + int'($urandom_range(0, 5)) - 1;
          v = m_y[b] + int'($urandom_range(0, 5)) - 1;
        end else begin
          h = $urandom_range(0, 639);
          v = $urandom_range(0, 479);
        end
        hpos = 10'(h);
        vpos = 10'(v);
        de  = ($urandom_range(0, 3) != 0);
        cwt = ($urandom_range(0, 5) == 0);
        stb = ($urandom_range(0, 1) == 0);
        cycle();
      end
    end
    reset_n = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
